// File: rtl/ps2_keyboard.sv
// ps2_keyboard
//   PS/2 keyboard receiver for the Hack KBD register. Deserialises
//   device-to-host frames, tracks E0 (extended) and F0 (break) prefixes,
//   translates scan-code set 2 into Hack key codes and holds the code of the
//   key currently pressed (0 when none).
//
//   Ports
//     clock_i       system clock, rising edge
//     reset_i       asynchronous active-low reset
//     ps2_clk_i     raw PS/2 clock pin (asynchronous)
//     ps2_data_i    raw PS/2 data pin (asynchronous)
//     key_o         Hack key code of the held key, bits 15:8 always 0
//     key_strobe_o  one-cycle pulse when key_o takes a new value
//     frame_err_o   one-cycle pulse on parity, stop-bit or timeout error
//
//   state        | meaning
//   ST_IDLE      | waiting for a start bit (data=0 on a clock fall)
//   ST_DATA      | shifting in 8 data bits, LSB first
//   ST_PARITY    | sampling the odd-parity bit
//   ST_STOP      | sampling the stop bit, releasing the byte
module ps2_keyboard #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic [15:0] key_o,
    output logic        key_strobe_o,
    output logic        frame_err_o
);

    localparam int             CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TC = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    logic                   fall_q;
    logic                   data_q;

    state_t                 state_q;
    logic [7:0]             shift_q;
    logic [2:0]             bit_cnt_q;
    logic                   par_ok_q;
    logic [CW-1:0]          tmo_cnt_q;
    logic [7:0]             byte_q;
    logic                   byte_valid_q;
    logic                   ext_q;
    logic                   brk_q;
    logic [7:0]             key_q;
    logic                   key_strobe_q;
    logic                   frame_err_q;
    logic [7:0]             code_d;

    function automatic logic [7:0] map_code(input logic ext, input logic [7:0] sc);
        logic [7:0] m;
        m = 8'd0;
        if (ext) begin
            case (sc)
                8'h6B: m = 8'd130;
                8'h75: m = 8'd131;
                8'h74: m = 8'd132;
                8'h72: m = 8'd133;
                8'h6C: m = 8'd134;
                8'h69: m = 8'd135;
                8'h7D: m = 8'd136;
                8'h7A: m = 8'd137;
                8'h70: m = 8'd138;
                8'h71: m = 8'd139;
                default: m = 8'd0;
            endcase
        end else begin
            case (sc)
                8'h1C: m = 8'd65;  8'h32: m = 8'd66;  8'h21: m = 8'd67;
                8'h23: m = 8'd68;  8'h24: m = 8'd69;  8'h2B: m = 8'd70;
                8'h34: m = 8'd71;  8'h33: m = 8'd72;  8'h43: m = 8'd73;
                8'h3B: m = 8'd74;  8'h42: m = 8'd75;  8'h4B: m = 8'd76;
                8'h3A: m = 8'd77;  8'h31: m = 8'd78;  8'h44: m = 8'd79;
                8'h4D: m = 8'd80;  8'h15: m = 8'd81;  8'h2D: m = 8'd82;
                8'h1B: m = 8'd83;  8'h2C: m = 8'd84;  8'h3C: m = 8'd85;
                8'h2A: m = 8'd86;  8'h1D: m = 8'd87;  8'h22: m = 8'd88;
                8'h35: m = 8'd89;  8'h1A: m = 8'd90;
                8'h45: m = 8'd48;  8'h16: m = 8'd49;  8'h1E: m = 8'd50;
                8'h26: m = 8'd51;  8'h25: m = 8'd52;  8'h2E: m = 8'd53;
                8'h36: m = 8'd54;  8'h3D: m = 8'd55;  8'h3E: m = 8'd56;
                8'h46: m = 8'd57;
                8'h29: m = 8'd32;  8'h5A: m = 8'd128; 8'h66: m = 8'd129;
                8'h76: m = 8'd140;
                8'h05: m = 8'd141; 8'h06: m = 8'd142; 8'h04: m = 8'd143;
                8'h0C: m = 8'd144; 8'h03: m = 8'd145; 8'h0B: m = 8'd146;
                8'h83: m = 8'd147; 8'h0A: m = 8'd148; 8'h01: m = 8'd149;
                8'h09: m = 8'd150; 8'h78: m = 8'd151; 8'h07: m = 8'd152;
                default: m = 8'd0;
            endcase
        end
        return m;
    endfunction

    assign code_d = map_code(ext_q, byte_q);

    // Synchroniser plus registered falling-edge detect; data is delayed
    // alongside so it lines up with fall_q.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            fall_q      <= 1'b0;
            data_q      <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
            fall_q      <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
            data_q      <= data_sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= ST_IDLE;
            shift_q      <= 8'd0;
            bit_cnt_q    <= 3'd0;
            par_ok_q     <= 1'b0;
            tmo_cnt_q    <= '0;
            byte_q       <= 8'd0;
            byte_valid_q <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            key_q        <= 8'd0;
            key_strobe_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            key_strobe_q <= 1'b0;
            frame_err_q  <= 1'b0;
            byte_valid_q <= 1'b0;

            // A clock fall always beats a coincident timeout terminal count.
            if (fall_q) begin
                tmo_cnt_q <= '0;
                case (state_q)
                    ST_IDLE: begin
                        if (!data_q) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {data_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_ok_q <= ^{shift_q, data_q};
                        state_q  <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (data_q && par_ok_q) begin
                            byte_q       <= shift_q;
                            byte_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q != ST_IDLE) begin
                if (tmo_cnt_q == TC) begin
                    state_q     <= ST_IDLE;
                    tmo_cnt_q   <= '0;
                    frame_err_q <= 1'b1;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
                end
            end

            if (byte_valid_q) begin
                if (byte_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                    if (code_d != 8'd0) begin
                        if (!brk_q) begin
                            key_q        <= code_d;
                            key_strobe_q <= (code_d != key_q);
                        end else if (code_d == key_q) begin
                            key_q        <= 8'd0;
                            key_strobe_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign key_o        = {8'd0, key_q};
    assign key_strobe_o = key_strobe_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
module tb_ps2_keyboard;

    localparam int SYNC = 2;
    localparam int TMO  = 300;
    localparam int HALF = 10;
    localparam int LAT  = SYNC + 3;

    logic        clock_i    = 1'b0;
    logic        reset_i    = 1'b0;
    logic        ps2_clk_i  = 1'b1;
    logic        ps2_data_i = 1'b1;
    logic [15:0] key_o;
    logic        key_strobe_o;
    logic        frame_err_o;

    ps2_keyboard #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .ps2_clk_i    (ps2_clk_i),
        .ps2_data_i   (ps2_data_i),
        .key_o        (key_o),
        .key_strobe_o (key_strobe_o),
        .frame_err_o  (frame_err_o)
    );

    always #5 clock_i = ~clock_i;

    int pcnt = 0;
    always @(posedge clock_i) pcnt <= pcnt + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [7:0] key;
        bit         strobe;
        bit         err;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] exp_key = 8'd0;
    logic [7:0] m_key = 8'd0;
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;
    int         win_lo = -1;
    int         win_hi = -1;
    int         win_pulses = 0;
    int         strobe_cnt = 0;
    int         err_cnt = 0;

    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] fkeys   [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01,
                                 8'h09, 8'h78, 8'h07};
    logic [7:0] extkeys [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, pcnt);
        end
    endtask

    function automatic logic [7:0] ref_map(input bit ext, input logic [7:0] sc);
        if (ext) begin
            for (int i = 0; i < 10; i++) if (extkeys[i] == sc) return 8'(130 + i);
            return 8'd0;
        end
        for (int i = 0; i < 26; i++) if (letters[i] == sc) return 8'(65 + i);
        for (int i = 0; i < 10; i++) if (digits[i] == sc) return 8'(48 + i);
        for (int i = 0; i < 12; i++) if (fkeys[i] == sc) return 8'(141 + i);
        case (sc)
            8'h29:   return 8'd32;
            8'h5A:   return 8'd128;
            8'h66:   return 8'd129;
            8'h76:   return 8'd140;
            default: return 8'd0;
        endcase
    endfunction

    // Byte-level keyboard model: schedules what the outputs must show,
    // counted from the posedge count at the moment of the last pin fall.
    task automatic model_frame(input logic [7:0] b, input bit bad, input int f);
        ev_t        e;
        logic [7:0] m;
        if (bad) begin
            e.cyc = f + LAT - 1; e.key = 8'd0; e.strobe = 1'b0; e.err = 1'b1;
            evq.push_back(e);
            return;
        end
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            m = ref_map(m_ext, b);
            if (m != 8'd0) begin
                if (!m_brk && m != m_key) begin
                    m_key = m;
                    e.cyc = f + LAT; e.key = m; e.strobe = 1'b1; e.err = 1'b0;
                    evq.push_back(e);
                end else if (m_brk && m == m_key) begin
                    m_key = 8'd0;
                    e.cyc = f + LAT; e.key = 8'd0; e.strobe = 1'b1; e.err = 1'b0;
                    evq.push_back(e);
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    always @(negedge clock_i) begin
        bit es;
        bit ee;
        es = 1'b0;
        ee = 1'b0;
        while (evq.size() > 0 && evq[0].cyc <= pcnt) begin
            if (evq[0].cyc == pcnt) begin
                if (evq[0].err) ee = 1'b1;
                else begin
                    exp_key = evq[0].key;
                    es      = evq[0].strobe;
                end
            end
            void'(evq.pop_front());
        end
        check("key", key_o, {24'd0, exp_key});
        check("key_strobe", key_strobe_o, es);
        if (pcnt >= win_lo && pcnt <= win_hi) begin
            if (frame_err_o) win_pulses++;
        end else begin
            check("frame_err", frame_err_o, ee);
        end
        if (key_strobe_o) strobe_cnt++;
        if (frame_err_o) err_cnt++;
    end

    task automatic send_frame(input logic [7:0] b, input bit bad);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data_i = bits[i];
            repeat (HALF) @(negedge clock_i);
            ps2_clk_i = 1'b0;
            if (i == 10) model_frame(b, bad, pcnt);
            repeat (HALF) @(negedge clock_i);
            ps2_clk_i = 1'b1;
        end
        ps2_data_i = 1'b1;
        repeat (2 * HALF) @(negedge clock_i);
    endtask

    // Start bit plus (n-1) data bits, then the clock stays high.
    task automatic send_partial(input logic [7:0] b, input int n, output int f);
        logic [10:0] bits;
        bits = {1'b1, ~^b, b, 1'b0};
        f = 0;
        for (int i = 0; i < n; i++) begin
            ps2_data_i = bits[i];
            repeat (HALF) @(negedge clock_i);
            ps2_clk_i = 1'b0;
            f = pcnt;
            repeat (HALF) @(negedge clock_i);
            ps2_clk_i = 1'b1;
        end
        ps2_data_i = 1'b1;
    endtask

    initial begin
        int s0;
        int e0;
        int f;

        repeat (4) @(negedge clock_i);
        check("rst_key", key_o, 0);
        check("rst_strobe", key_strobe_o, 0);
        check("rst_err", frame_err_o, 0);
        reset_i = 1'b1;
        repeat (5) @(negedge clock_i);

        // Make / break of A
        s0 = strobe_cnt;
        send_frame(8'h1C, 1'b0);
        check("A_make", key_o, 65);
        check("A_make_strobes", strobe_cnt - s0, 1);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("A_break", key_o, 0);
        check("A_break_strobes", strobe_cnt - s0, 2);

        // Extended up arrow, then a lone 6B
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("up_make", key_o, 131);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("up_break", key_o, 0);
        s0 = strobe_cnt;
        send_frame(8'h6B, 1'b0);
        check("lone_6B", key_o, 0);
        check("lone_6B_strobes", strobe_cnt - s0, 0);

        // Parity error
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1);
        check("parity_err_pulses", err_cnt - e0, 1);
        check("parity_err_key", key_o, 0);
        send_frame(8'h16, 1'b0);
        check("digit1", key_o, 49);

        // Timeout on a partial frame
        send_partial(8'h29, 5, f);
        win_pulses = 0;
        win_lo = f + TMO;
        win_hi = f + TMO + 8;
        repeat (TMO + 20) @(negedge clock_i);
        win_lo = -1;
        win_hi = -1;
        check("timeout_pulses", win_pulses, 1);
        send_frame(8'h29, 1'b0);
        check("space", key_o, 32);

        // Held key and break of a different key
        s0 = strobe_cnt;
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("hold_key", key_o, 65);
        check("hold_strobes", strobe_cnt - s0, 1);
        send_frame(8'h32, 1'b0);
        check("B_make", key_o, 66);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check("other_break", key_o, 66);
        check("other_break_strobes", strobe_cnt - s0, 2);

        // Asynchronous reset mid-frame
        e0 = err_cnt;
        send_partial(8'h5A, 5, f);
        #2;
        reset_i = 1'b0;
        #1;
        check("async_rst_key", key_o, 0);
        exp_key = 8'd0;
        m_key = 8'd0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        evq.delete();
        repeat (3) @(negedge clock_i);
        reset_i = 1'b1;
        repeat (5) @(negedge clock_i);
        send_frame(8'h5A, 1'b0);
        check("enter", key_o, 128);
        check("rst_no_err", err_cnt - e0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
